vga2_copper: RTL and testbench

- Display-list coprocessor that sequences updates to the VGA2 object RAM / register space in step with the raster.
- Each frame it fetches a command list from memory and executes WRITE, WAIT, JUMP and END commands, issuing single-word register writes at the programmed scanlines.
- Also arbitrates the shared vga_reg_* write port between these copper writes and direct CPU writes, which take priority.

---
 rtl/vga2_copper.sv | 177 +++++++++++++++++
 tb/tb_vga2_copper.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vga2_copper.sv
// Display-list copper for VGA2: fetches WRITE/WAIT/JUMP/END commands each frame and
// issues raster-timed register writes, sharing the register write port with the CPU.
//
// state      | meaning
// IDLE       | copper disabled, waiting for start_of_frame
// FETCH_OP   | fetching the next command word
// FETCH_DATA | fetching the data word of a WRITE
// WRITE      | issuing the copper write (retries while the CPU owns the port)
// WAIT_Y     | stalled until scanline_y reaches the programmed line
// FETCH_JUMP | fetching the jump target
// HALT       | list finished or runaway guard tripped, waiting for next frame
module vga2_copper #(
    parameter int MAX_OPS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_of_frame,
    input  logic [9:0]  scanline_y,
    input  logic        enable,
    input  logic [31:0] list_base,
    output logic        fetch_req,
    output logic [31:0] fetch_addr,
    input  logic        fetch_ack,
    input  logic [31:0] fetch_rdata,
    input  logic        cpu_write,
    input  logic [13:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    output logic        vga_reg_write,
    output logic [13:0] vga_reg_address,
    output logic [31:0] vga_reg_wdata,
    output logic        busy,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_OP,
        S_FETCH_DATA,
        S_WRITE,
        S_WAIT_Y,
        S_FETCH_JUMP,
        S_HALT
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [15:0] op_count, op_count_next;
    logic [15:0] op_count_inc;
    logic        req_hold, req_hold_next;
    logic [13:0] wr_addr, wr_addr_next;
    logic [31:0] wr_data, wr_data_next;
    logic [9:0]  wait_y, wait_y_next;
    logic        in_fetch;
    logic        ack;
    logic        copper_write;

    // req_hold forces the mandatory idle cycle after every accepted word and after a restart
    assign in_fetch     = (state == S_FETCH_OP) || (state == S_FETCH_DATA) || (state == S_FETCH_JUMP);
    assign fetch_req    = in_fetch && !req_hold;
    assign fetch_addr   = pc;
    assign ack          = fetch_ack && fetch_req;
    assign busy         = (state != S_IDLE) && (state != S_HALT);
    assign halted       = (state == S_HALT);
    assign op_count_inc = op_count + 16'd1;

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        op_count_next = op_count;
        req_hold_next = 1'b0;
        wr_addr_next  = wr_addr;
        wr_data_next  = wr_data;
        wait_y_next   = wait_y;
        copper_write  = 1'b0;

        if (start_of_frame) begin
            if (enable) begin
                state_next    = S_FETCH_OP;
                pc_next       = {list_base[31:2], 2'b00};
                op_count_next = 16'd0;
                req_hold_next = 1'b1;
            end else begin
                state_next = S_IDLE;
            end
        end else begin
            case (state)
                S_FETCH_OP: begin
                    if (ack) begin
                        pc_next       = pc + 32'd4;
                        op_count_next = op_count_inc;
                        req_hold_next = 1'b1;
                        if (op_count_inc == 16'(MAX_OPS)) begin
                            state_next = S_HALT;
                        end else begin
                            case (fetch_rdata[31:30])
                                2'b00: begin
                                    wr_addr_next = fetch_rdata[13:0];
                                    state_next   = S_FETCH_DATA;
                                end
                                2'b01: begin
                                    wait_y_next = fetch_rdata[9:0];
                                    state_next  = S_WAIT_Y;
                                end
                                2'b10:   state_next = S_FETCH_JUMP;
                                default: state_next = S_HALT;
                            endcase
                        end
                    end
                end
                S_FETCH_DATA: begin
                    if (ack) begin
                        wr_data_next  = fetch_rdata;
                        pc_next       = pc + 32'd4;
                        req_hold_next = 1'b1;
                        state_next    = S_WRITE;
                    end
                end
                S_WRITE: begin
                    if (!cpu_write) begin
                        copper_write = 1'b1;
                        state_next   = S_FETCH_OP;
                    end
                end
                S_WAIT_Y: begin
                    if (scanline_y >= wait_y) state_next = S_FETCH_OP;
                end
                S_FETCH_JUMP: begin
                    if (ack) begin
                        pc_next       = {fetch_rdata[31:2], 2'b00};
                        req_hold_next = 1'b1;
                        state_next    = S_FETCH_OP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            pc       <= 32'd0;
            op_count <= 16'd0;
            req_hold <= 1'b0;
            wr_addr  <= 14'd0;
            wr_data  <= 32'd0;
            wait_y   <= 10'd0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            op_count <= op_count_next;
            req_hold <= req_hold_next;
            wr_addr  <= wr_addr_next;
            wr_data  <= wr_data_next;
            wait_y   <= wait_y_next;
        end
    end

    // CPU has priority; the copper only issues in cycles without a CPU strobe
    always_ff @(posedge clock) begin
        if (reset) begin
            vga_reg_write   <= 1'b0;
            vga_reg_address <= 14'd0;
            vga_reg_wdata   <= 32'd0;
        end else begin
            vga_reg_write <= cpu_write || copper_write;
            if (cpu_write) begin
                vga_reg_address <= cpu_address;
                vga_reg_wdata   <= cpu_wdata;
            end else if (copper_write) begin
                vga_reg_address <= wr_addr;
                vga_reg_wdata   <= wr_data;
            end
        end
    end

endmodule

// File: tb/tb_vga2_copper.sv
// Directed bench for vga2_copper: zero-wait list memory model, fetch/write logging,
// hand-computed expectations for each command sequence.
module tb_vga2_copper;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_of_frame;
    logic [9:0]  scanline_y;
    logic        enable;
    logic [31:0] list_base;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_ack;
    logic [31:0] fetch_rdata;
    logic        cpu_write;
    logic [13:0] cpu_address;
    logic [31:0] cpu_wdata;
    logic        vga_reg_write;
    logic [13:0] vga_reg_address;
    logic [31:0] vga_reg_wdata;
    logic        busy;
    logic        halted;

    logic        auto_ack;
    logic        force_ack;
    logic [31:0] mem [0:63];
    logic [31:0] fq[$];
    logic [45:0] wq[$];
    int          op_acks;
    int          n_checks = 0;
    int          n_errors = 0;

    vga2_copper #(.MAX_OPS(1024)) dut (
        .clock(clock), .reset(reset), .start_of_frame(start_of_frame),
        .scanline_y(scanline_y), .enable(enable), .list_base(list_base),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ack(fetch_ack),
        .fetch_rdata(fetch_rdata), .cpu_write(cpu_write), .cpu_address(cpu_address),
        .cpu_wdata(cpu_wdata), .vga_reg_write(vga_reg_write),
        .vga_reg_address(vga_reg_address), .vga_reg_wdata(vga_reg_wdata),
        .busy(busy), .halted(halted)
    );

    always #5 clock = ~clock;

    // list memory lives at 0x1000; fetch_req is register-derived so a combinational ack is race-free
    assign fetch_ack   = (auto_ack && fetch_req) || force_ack;
    assign fetch_rdata = mem[fetch_addr[7:2]];

    always @(negedge clock) begin
        if (fetch_ack && fetch_req) begin
            fq.push_back(fetch_addr);
            if (fetch_addr == 32'h1000) op_acks++;
        end
        if (vga_reg_write) wq.push_back({vga_reg_address, vga_reg_wdata});
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic sof_pulse(input logic en);
        @(negedge clock);
        start_of_frame = 1'b1;
        enable         = en;
        @(negedge clock);
        start_of_frame = 1'b0;
    endtask

    task automatic wait_halt(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (halted) break;
        end
        check(tag, 64'(halted), 64'd1);
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'hC000_0000;
    endtask

    initial begin
        reset = 1'b1; start_of_frame = 1'b0; scanline_y = 10'd0; enable = 1'b0;
        list_base = 32'h0000_1003; cpu_write = 1'b0; cpu_address = 14'd0; cpu_wdata = 32'd0;
        auto_ack = 1'b1; force_ack = 1'b0; op_acks = 0;
        clear_mem();
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rst_fetch_req", 64'(fetch_req), 64'd0);
        check("rst_fetch_addr", 64'(fetch_addr), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_wr", 64'(vga_reg_write), 64'd0);
        check("rst_wr_addr", 64'(vga_reg_address), 64'd0);
        check("rst_wr_data", 64'(vga_reg_wdata), 64'd0);

        // single WRITE then END; list_base low bits must be dropped
        mem[0] = 32'h0000_0010; mem[1] = 32'hDEAD_BEEF; mem[2] = 32'hC000_0000;
        fq.delete(); wq.delete();
        sof_pulse(1'b1);
        wait_halt("t1_halt", 50);
        check("t1_busy", 64'(busy), 64'd0);
        check("t1_nwr", 64'(wq.size()), 64'd1);
        if (wq.size() > 0) check("t1_wr", 64'(wq[0]), {18'd0, 14'h0010, 32'hDEAD_BEEF});
        if (fq.size() > 0) check("t1_addr0", 64'(fq[0]), 64'h1000);
        repeat (10) @(negedge clock);
        check("t1_nfetch", 64'(fq.size()), 64'd3);
        check("t1_req_idle", 64'(fetch_req), 64'd0);

        // WAIT 100 with scanline stepped 98 -> 99 -> 100
        clear_mem();
        mem[0] = 32'h4000_0064; mem[1] = 32'h0000_0004; mem[2] = 32'h1234_5678; mem[3] = 32'hC000_0000;
        list_base = 32'h0000_1000; scanline_y = 10'd98;
        fq.delete(); wq.delete();
        sof_pulse(1'b1);
        repeat (6) @(negedge clock);
        check("t2_req98", 64'(fetch_req), 64'd0);
        check("t2_nf98", 64'(fq.size()), 64'd1);
        scanline_y = 10'd99;
        repeat (4) @(negedge clock);
        check("t2_req99", 64'(fetch_req), 64'd0);
        check("t2_nf99", 64'(fq.size()), 64'd1);
        scanline_y = 10'd100;
        @(negedge clock);
        check("t2_release_req", 64'(fetch_req), 64'd1);
        check("t2_release_addr", 64'(fetch_addr), 64'h1004);
        wait_halt("t2_halt", 50);
        check("t2_nfetch", 64'(fq.size()), 64'd4);
        for (int i = 0; i < 4 && i < fq.size(); i++)
            check($sformatf("t2_faddr%0d", i), 64'(fq[i]), 64'(32'h1000 + 32'(4 * i)));
        check("t2_nwr", 64'(wq.size()), 64'd1);
        if (wq.size() > 0) check("t2_wr", 64'(wq[0]), {18'd0, 14'h0004, 32'h1234_5678});

        // CPU holds the port for 3 cycles while the copper sits in WRITE
        clear_mem();
        mem[0] = 32'h4000_00C8; mem[1] = 32'h0000_0020; mem[2] = 32'hCAFE_F00D; mem[3] = 32'hC000_0000;
        scanline_y = 10'd0;
        fq.delete(); wq.delete();
        sof_pulse(1'b1);
        repeat (6) @(negedge clock);
        scanline_y = 10'd200;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (fetch_req && fetch_addr == 32'h1008) break;
        end
        check("t3_reach_data", 64'(fetch_addr), 64'h1008);
        @(negedge clock);
        cpu_write = 1'b1; cpu_address = 14'h3FFF; cpu_wdata = 32'h1;
        repeat (3) @(negedge clock);
        cpu_write = 1'b0;
        @(negedge clock);
        check("t3_copper_follows", 64'(vga_reg_write), 64'd1);
        wait_halt("t3_halt", 50);
        check("t3_nwr", 64'(wq.size()), 64'd4);
        for (int i = 0; i < 3 && i < wq.size(); i++)
            check($sformatf("t3_cpu%0d", i), 64'(wq[i]), {18'd0, 14'h3FFF, 32'h1});
        if (wq.size() > 3) check("t3_copper", 64'(wq[3]), {18'd0, 14'h0020, 32'hCAFE_F00D});

        // JUMP self-loop: runaway guard after exactly 1024 opcode fetches
        clear_mem();
        mem[0] = 32'h8000_0000; mem[1] = 32'h0000_1000;
        op_acks = 0;
        sof_pulse(1'b1);
        wait_halt("t4_halt", 6000);
        check("t4_opacks", 64'(op_acks), 64'd1024);
        sof_pulse(1'b1);
        check("t4_restart_halted", 64'(halted), 64'd0);
        check("t4_restart_busy", 64'(busy), 64'd1);
        @(negedge clock);
        check("t4_restart_req", 64'(fetch_req), 64'd1);
        check("t4_restart_addr", 64'(fetch_addr), 64'h1000);

        // restart while a fetch is outstanding; ack in the drop cycle must be ignored
        repeat (200) @(negedge clock);
        auto_ack = 1'b0;
        @(negedge clock);
        check("t5_req_pending", 64'(fetch_req), 64'd1);
        sof_pulse(1'b1);
        check("t5_drop", 64'(fetch_req), 64'd0);
        force_ack = 1'b1;
        @(negedge clock);
        force_ack = 1'b0;
        check("t5_req_after", 64'(fetch_req), 64'd1);
        check("t5_addr_after", 64'(fetch_addr), 64'h1000);
        op_acks = 0;
        auto_ack = 1'b1;
        wait_halt("t5_halt", 6000);
        check("t5_opacks", 64'(op_acks), 64'd1024);

        // enable=0: copper idles, CPU writes still pass with one cycle of latency
        fq.delete();
        sof_pulse(1'b0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_halted", 64'(halted), 64'd0);
        repeat (5) @(negedge clock);
        check("t6_nfetch", 64'(fq.size()), 64'd0);
        cpu_write = 1'b1; cpu_address = 14'h0ABC; cpu_wdata = 32'h0000_55AA;
        @(negedge clock);
        cpu_write = 1'b0; cpu_address = 14'h0111; cpu_wdata = 32'h0;
        check("t6_wr", 64'(vga_reg_write), 64'd1);
        check("t6_wr_addr", 64'(vga_reg_address), 64'h0ABC);
        check("t6_wr_data", 64'(vga_reg_wdata), 64'h55AA);
        @(negedge clock);
        check("t6_wr_pulse", 64'(vga_reg_write), 64'd0);
        check("t6_addr_hold", 64'(vga_reg_address), 64'h0ABC);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
